// File: rtl/arp_pkg.sv
// ARP controller shared definitions: opcodes, broadcast MAC, FSM states, peer record.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package arp_pkg;

    localparam logic [15:0] ARP_OP_REQ = 16'h0001;
    localparam logic [15:0] ARP_OP_RPL = 16'h0002;
    localparam logic [47:0] MAC_BCAST  = 48'hFFFF_FFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ_TX   = 2'd1,
        REQ_WAIT = 2'd2,
        RPL_TX   = 2'd3
    } arp_state_t;

    // Sender of a received ARP request that still needs a reply.
    typedef struct packed {
        logic [47:0] mac;
        logic [31:0] ip;
    } arp_peer_t;

endpackage

// File: rtl/arp_retry_timer.sv
// Retry timer: counts enabled, unfrozen cycles and flags the last cycle of the wait.
// Latency: expired is combinational from the count; the count updates one cycle later.
// Backpressure: freeze holds the count and masks expiry; clr wins over everything.
//
// Ports: clk/rstn clock and async active-low reset; clr zeroes the count;
//        en lets the count advance; freeze holds it; expired marks count==RETRY_CYCLES-1.
module arp_retry_timer #(
    parameter logic [31:0] RETRY_CYCLES = 32'd1_000_000
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    input  logic en,
    input  logic freeze,
    output logic expired
);

    logic [31:0] cnt;

    assign expired = en && !freeze && (cnt == (RETRY_CYCLES - 32'd1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= 32'd0;
        end else if (clr) begin
            cnt <= 32'd0;
        end else if (en && !freeze) begin
            // Wrap on expiry so the counter never runs past the window.
            cnt <= expired ? 32'd0 : cnt + 32'd1;
        end
    end

endmodule

// File: rtl/arp_ctrl.sv
// ARP resolver: broadcasts requests for a target IP with timed retries, caches the
// peer MAC on a hit, and answers ARP requests addressed to local_ip.
// Latency: start -> request one cycle later; hit -> peer_mac_valid next cycle.
// Backpressure: arp_tx_* held stable until arp_tx_ack; one pending reply, newest wins.
//
// Ports: clk, rstn (async active-low); start/target_ip begin a resolution;
//        local_mac/local_ip identify this node; arp_rx_* is the parsed-frame strobe;
//        arp_tx_req/ack + arp_tx_op/dst_mac/dst_ip drive the frame builder;
//        peer_mac/peer_mac_valid, resolve_fail and busy report resolution status.
module arp_ctrl
    import arp_pkg::*;
#(
    parameter logic [31:0] RETRY_CYCLES = 32'd1_000_000,
    parameter int          MAX_RETRY    = 3
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic [47:0] local_mac,
    input  logic [31:0] local_ip,
    input  logic [31:0] target_ip,
    input  logic        arp_rx_valid,
    input  logic [15:0] arp_rx_op,
    input  logic [47:0] arp_rx_src_mac,
    input  logic [31:0] arp_rx_src_ip,
    input  logic [31:0] arp_rx_dst_ip,
    output logic        arp_tx_req,
    input  logic        arp_tx_ack,
    output logic [15:0] arp_tx_op,
    output logic [47:0] arp_tx_dst_mac,
    output logic [31:0] arp_tx_dst_ip,
    output logic [47:0] peer_mac,
    output logic        peer_mac_valid,
    output logic        resolve_fail,
    output logic        busy
);

    localparam int            RW          = $clog2(MAX_RETRY + 1);
    localparam logic [RW-1:0] MAX_RETRY_W = RW'(MAX_RETRY);

    arp_state_t    state, state_nxt;
    logic [31:0]   tgt_ip;
    logic [RW-1:0] retry_cnt;
    arp_peer_t     rpl_q;
    logic          rpl_pend;

    logic hit;
    logic rpl_cap;
    logic take_start;
    logic do_resolve;
    logic do_fail;
    logic tmr_clr;
    logic tmr_en;
    logic tmr_freeze;
    logic tmr_exp;
    logic enter_req;
    logic enter_rpl;

    // MAC source address is inserted by the frame builder, not here.
    logic unused_local_mac;
    assign unused_local_mac = ^local_mac;

    assign hit     = arp_rx_valid && (arp_rx_src_ip == tgt_ip) &&
                     ((arp_rx_op == ARP_OP_REQ) || (arp_rx_op == ARP_OP_RPL));
    assign rpl_cap = arp_rx_valid && (arp_rx_op == ARP_OP_REQ) &&
                     (arp_rx_dst_ip == local_ip);

    // A pending reply is served before the wait window continues, so the count
    // holds both while the reply is waiting to go out and while it is on the wire.
    assign tmr_en     = (state == REQ_WAIT);
    assign tmr_freeze = (state == RPL_TX) || rpl_pend;

    arp_retry_timer #(
        .RETRY_CYCLES(RETRY_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rstn   (rstn),
        .clr    (tmr_clr),
        .en     (tmr_en),
        .freeze (tmr_freeze),
        .expired(tmr_exp)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        take_start = 1'b0;
        do_resolve = 1'b0;
        do_fail    = 1'b0;
        tmr_clr    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt  = REQ_TX;
                    take_start = 1'b1;
                end else if (rpl_pend) begin
                    state_nxt = RPL_TX;
                end
            end
            REQ_TX: begin
                // Pending replies never preempt a request already being offered.
                if (arp_tx_ack) begin
                    state_nxt = REQ_WAIT;
                    tmr_clr   = 1'b1;
                end
            end
            REQ_WAIT: begin
                // Priority: hit, then pending reply, then expiry.
                if (hit) begin
                    state_nxt  = IDLE;
                    do_resolve = 1'b1;
                end else if (rpl_pend) begin
                    state_nxt = RPL_TX;
                end else if (tmr_exp) begin
                    if (retry_cnt == MAX_RETRY_W) begin
                        state_nxt = IDLE;
                        do_fail   = 1'b1;
                    end else begin
                        state_nxt = REQ_TX;
                    end
                end
            end
            RPL_TX: begin
                if (arp_tx_ack) begin
                    state_nxt = busy ? REQ_WAIT : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign enter_req  = (state_nxt == REQ_TX) && (state != REQ_TX);
    assign enter_rpl  = (state_nxt == RPL_TX) && (state != RPL_TX);
    assign arp_tx_req = (state == REQ_TX) || (state == RPL_TX);

    // Resolution status, target and retry count.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tgt_ip         <= 32'd0;
            retry_cnt      <= '0;
            peer_mac       <= 48'd0;
            peer_mac_valid <= 1'b0;
            resolve_fail   <= 1'b0;
            busy           <= 1'b0;
        end else begin
            if (take_start) begin
                // start beats a simultaneous hit: the cache is left untouched.
                tgt_ip         <= target_ip;
                retry_cnt      <= '0;
                peer_mac_valid <= 1'b0;
                resolve_fail   <= 1'b0;
                busy           <= 1'b1;
            end else if (hit) begin
                peer_mac       <= arp_rx_src_mac;
                peer_mac_valid <= 1'b1;
            end
            if (do_resolve) begin
                busy         <= 1'b0;
                resolve_fail <= 1'b0;
            end
            if (do_fail) begin
                busy         <= 1'b0;
                resolve_fail <= 1'b1;
            end
            if ((state == REQ_TX) && arp_tx_ack && (retry_cnt != MAX_RETRY_W)) begin
                retry_cnt <= retry_cnt + RW'(1);
            end
        end
    end

    // One-deep reply latch. Pending drops when its contents are copied into the
    // transmit registers, so a request captured while a reply is on offer (including
    // the acceptance cycle) stays pending and is answered next.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rpl_q    <= '0;
            rpl_pend <= 1'b0;
        end else if (rpl_cap) begin
            rpl_q.mac <= arp_rx_src_mac;
            rpl_q.ip  <= arp_rx_src_ip;
            rpl_pend  <= 1'b1;
        end else if (enter_rpl) begin
            rpl_pend <= 1'b0;
        end
    end

    // Transmit fields load only on entry to a transmit state and are otherwise held,
    // which keeps them stable across the whole handshake.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            arp_tx_op      <= 16'd0;
            arp_tx_dst_mac <= 48'd0;
            arp_tx_dst_ip  <= 32'd0;
        end else if (enter_req) begin
            arp_tx_op      <= ARP_OP_REQ;
            arp_tx_dst_mac <= MAC_BCAST;
            arp_tx_dst_ip  <= take_start ? target_ip : tgt_ip;
        end else if (enter_rpl) begin
            arp_tx_op      <= ARP_OP_RPL;
            arp_tx_dst_mac <= rpl_q.mac;
            arp_tx_dst_ip  <= rpl_q.ip;
        end
    end

endmodule

// File: tb/tb_arp_ctrl.sv
module tb_arp_ctrl;

    localparam logic [47:0] LMAC = 48'h02_00_00_00_00_01;
    localparam logic [31:0] LIP  = 32'h0A00_0001;
    localparam logic [31:0] TGT  = 32'h0A00_0002;
    localparam logic [47:0] M5   = 48'h02_00_00_00_00_05;
    localparam logic [47:0] MAA  = 48'h02_00_00_00_00_AA;
    localparam logic [47:0] MA   = 48'h02_00_00_00_00_09;
    localparam logic [31:0] IA   = 32'h0A00_0009;
    localparam logic [47:0] MB   = 48'h02_00_00_00_00_0B;
    localparam logic [31:0] IB   = 32'h0A00_000B;
    localparam logic [47:0] MC   = 48'h02_00_00_00_00_0C;
    localparam logic [31:0] IC   = 32'h0A00_000C;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic [47:0] local_mac;
    logic [31:0] local_ip;
    logic [31:0] target_ip;
    logic        arp_rx_valid;
    logic [15:0] arp_rx_op;
    logic [47:0] arp_rx_src_mac;
    logic [31:0] arp_rx_src_ip;
    logic [31:0] arp_rx_dst_ip;
    logic        arp_tx_req;
    logic        arp_tx_ack;
    logic [15:0] arp_tx_op;
    logic [47:0] arp_tx_dst_mac;
    logic [31:0] arp_tx_dst_ip;
    logic [47:0] peer_mac;
    logic        peer_mac_valid;
    logic        resolve_fail;
    logic        busy;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    int          log_cyc[$];
    logic [15:0] log_op[$];
    logic [47:0] log_mac[$];
    logic [31:0] log_ip[$];

    arp_ctrl #(
        .RETRY_CYCLES(32'd100),
        .MAX_RETRY   (3)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .start         (start),
        .local_mac     (local_mac),
        .local_ip      (local_ip),
        .target_ip     (target_ip),
        .arp_rx_valid  (arp_rx_valid),
        .arp_rx_op     (arp_rx_op),
        .arp_rx_src_mac(arp_rx_src_mac),
        .arp_rx_src_ip (arp_rx_src_ip),
        .arp_rx_dst_ip (arp_rx_dst_ip),
        .arp_tx_req    (arp_tx_req),
        .arp_tx_ack    (arp_tx_ack),
        .arp_tx_op     (arp_tx_op),
        .arp_tx_dst_mac(arp_tx_dst_mac),
        .arp_tx_dst_ip (arp_tx_dst_ip),
        .peer_mac      (peer_mac),
        .peer_mac_valid(peer_mac_valid),
        .resolve_fail  (resolve_fail),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Handshake log, sampled mid-cycle; inputs change 1 time unit after posedge.
    always @(negedge clk) begin
        if (rstn && arp_tx_req && arp_tx_ack) begin
            log_cyc.push_back(cyc);
            log_op.push_back(arp_tx_op);
            log_mac.push_back(arp_tx_dst_mac);
            log_ip.push_back(arp_tx_dst_ip);
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rx_drive(input logic [15:0] op, input logic [47:0] mac,
                            input logic [31:0] ip, input logic [31:0] dst);
        arp_rx_valid   = 1'b1;
        arp_rx_op      = op;
        arp_rx_src_mac = mac;
        arp_rx_src_ip  = ip;
        arp_rx_dst_ip  = dst;
    endtask

    task automatic do_reset();
        rstn         = 1'b0;
        start        = 1'b0;
        target_ip    = TGT;
        arp_rx_valid = 1'b0;
        arp_rx_op    = 16'd0;
        arp_rx_src_mac = 48'd0;
        arp_rx_src_ip  = 32'd0;
        arp_rx_dst_ip  = 32'd0;
        arp_tx_ack   = 1'b1;
        step(2);
        rstn = 1'b1;
        step(1);
    endtask

    task automatic test_reset();
        rstn         = 1'b0;
        start        = 1'b0;
        local_mac    = LMAC;
        local_ip     = LIP;
        target_ip    = TGT;
        arp_rx_valid = 1'b0;
        arp_rx_op    = 16'd0;
        arp_rx_src_mac = 48'd0;
        arp_rx_src_ip  = 32'd0;
        arp_rx_dst_ip  = 32'd0;
        arp_tx_ack   = 1'b1;
        step(2);
        tests++;
        if ({arp_tx_req, peer_mac_valid, resolve_fail, busy} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_flags: got %b required 0000",
                     {arp_tx_req, peer_mac_valid, resolve_fail, busy});
        end
        tests++;
        if ({arp_tx_op, arp_tx_dst_mac, arp_tx_dst_ip, peer_mac} !== 144'd0) begin
            fails++;
            $display("FAIL reset_fields: got op=%h mac=%h ip=%h peer=%h required all 0",
                     arp_tx_op, arp_tx_dst_mac, arp_tx_dst_ip, peer_mac);
        end
        rstn = 1'b1;
        step(1);
    endtask

    // No rx: three requests 101 cycles apart, failure 100 cycles after the third.
    task automatic test_retry_fail();
        int base;
        int n;
        base = log_op.size();
        start = 1'b1;
        step(1);
        start = 1'b0;
        n = 1;
        while (busy && n < 600) begin
            step(1);
            n++;
        end
        tests++;
        if (n !== 304) begin
            fails++;
            $display("FAIL fail_timing: busy dropped after %0d cycles required 304", n);
        end
        tests++;
        if ({resolve_fail, busy, peer_mac_valid} !== 3'b100) begin
            fails++;
            $display("FAIL fail_status: got fail/busy/valid=%b required 100",
                     {resolve_fail, busy, peer_mac_valid});
        end
        tests++;
        if (log_op.size() - base !== 3) begin
            fails++;
            $display("FAIL fail_req_count: got %0d requests required 3", log_op.size() - base);
        end else begin
            tests++;
            if ((log_cyc[base+1] - log_cyc[base] !== 101) ||
                (log_cyc[base+2] - log_cyc[base+1] !== 101)) begin
                fails++;
                $display("FAIL retry_spacing: got %0d,%0d required 101,101",
                         log_cyc[base+1] - log_cyc[base], log_cyc[base+2] - log_cyc[base+1]);
            end
            tests++;
            if ({log_op[base+2], log_mac[base+2], log_ip[base+2]} !==
                {16'h0001, 48'hFFFF_FFFF_FFFF, TGT}) begin
                fails++;
                $display("FAIL req_fields: got op=%h mac=%h ip=%h required 0001 ffffffffffff %h",
                         log_op[base+2], log_mac[base+2], log_ip[base+2], TGT);
            end
        end
    endtask

    // Reply after the first request resolves and stops retrying.
    task automatic test_resolve();
        int base;
        base = log_op.size();
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(8);
        rx_drive(16'h0002, M5, TGT, LIP);
        step(1);
        arp_rx_valid = 1'b0;
        tests++;
        if ({peer_mac, peer_mac_valid, busy, resolve_fail} !== {48'h0200_0000_0005, 3'b100}) begin
            fails++;
            $display("FAIL resolve_status: got peer=%h valid=%b busy=%b fail=%b required 020000000005 1 0 0",
                     peer_mac, peer_mac_valid, busy, resolve_fail);
        end
        step(250);
        tests++;
        if (log_op.size() - base !== 1) begin
            fails++;
            $display("FAIL resolve_no_retry: got %0d requests required 1", log_op.size() - base);
        end
    endtask

    // Request to local_ip in IDLE with ack held low; newer requests overwrite the latch.
    task automatic test_reply_idle();
        int   base;
        logic stable;
        base = log_op.size();
        arp_tx_ack = 1'b0;
        rx_drive(16'h0001, MA, IA, LIP);
        step(1);
        arp_rx_valid = 1'b0;
        step(1);
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if ({arp_tx_req, arp_tx_op, arp_tx_dst_mac, arp_tx_dst_ip} !== {1'b1, 16'h0002, MA, IA})
                stable = 1'b0;
            if (i == 3) rx_drive(16'h0001, MB, IB, LIP);
            else if (i == 5) rx_drive(16'h0001, MC, IC, LIP);
            else arp_rx_valid = 1'b0;
            step(1);
        end
        arp_rx_valid = 1'b0;
        tests++;
        if (stable !== 1'b1) begin
            fails++;
            $display("FAIL reply_stable: got stable=%b required 1", stable);
        end
        tests++;
        if ({arp_tx_req, arp_tx_op, arp_tx_dst_mac, arp_tx_dst_ip} !== {1'b1, 16'h0002, MA, IA}) begin
            fails++;
            $display("FAIL reply_fields: got req=%b op=%h mac=%h ip=%h required 1 0002 %h %h",
                     arp_tx_req, arp_tx_op, arp_tx_dst_mac, arp_tx_dst_ip, MA, IA);
        end
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL reply_busy: got %b required 0", busy);
        end
        arp_tx_ack = 1'b1;
        step(1);
        tests++;
        if (arp_tx_req !== 1'b0) begin
            fails++;
            $display("FAIL reply_req_drop: got %b required 0", arp_tx_req);
        end
        step(1);
        tests++;
        if ({arp_tx_req, arp_tx_dst_ip} !== {1'b1, IC}) begin
            fails++;
            $display("FAIL reply_newest: got req=%b ip=%h required 1 %h", arp_tx_req, arp_tx_dst_ip, IC);
        end
        step(4);
        tests++;
        if (log_op.size() - base !== 2) begin
            fails++;
            $display("FAIL reply_count: got %0d replies required 2", log_op.size() - base);
        end else begin
            tests++;
            if ({log_mac[base+1], log_ip[base+1]} !== {MC, IC}) begin
                fails++;
                $display("FAIL reply_overwrite: got mac=%h ip=%h required %h %h",
                         log_mac[base+1], log_ip[base+1], MC, IC);
            end
        end
    endtask

    // Request to local_ip at timer=50 in REQ_WAIT: reply, then the wait resumes.
    task automatic test_reply_during_wait();
        int base;
        base = log_op.size();
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(51);
        rx_drive(16'h0001, MB, IB, LIP);
        step(1);
        arp_rx_valid = 1'b0;
        step(60);
        tests++;
        if (log_op.size() - base !== 3) begin
            fails++;
            $display("FAIL wait_count: got %0d handshakes required 3", log_op.size() - base);
        end else begin
            tests++;
            if ({log_op[base+1], log_ip[base+1], log_op[base+2]} !== {16'h0002, IB, 16'h0001}) begin
                fails++;
                $display("FAIL wait_order: got op1=%h ip1=%h op2=%h required 0002 %h 0001",
                         log_op[base+1], log_ip[base+1], log_op[base+2], IB);
            end
            tests++;
            if ((log_cyc[base+1] - log_cyc[base] !== 53) ||
                (log_cyc[base+2] - log_cyc[base+1] !== 50)) begin
                fails++;
                $display("FAIL wait_freeze: got %0d,%0d required 53,50",
                         log_cyc[base+1] - log_cyc[base], log_cyc[base+2] - log_cyc[base+1]);
            end
        end
    endtask

    // Hit on the expiry cycle wins; restart clears valid; start beats a same-cycle hit.
    task automatic test_hit_on_expiry();
        int base;
        base = log_op.size();
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(100);
        rx_drive(16'h0002, M5, TGT, LIP);
        step(1);
        arp_rx_valid = 1'b0;
        tests++;
        if ({peer_mac, peer_mac_valid, busy} !== {M5, 2'b10}) begin
            fails++;
            $display("FAIL expiry_hit: got peer=%h valid=%b busy=%b required %h 1 0",
                     peer_mac, peer_mac_valid, busy, M5);
        end
        step(150);
        tests++;
        if (log_op.size() - base !== 1) begin
            fails++;
            $display("FAIL expiry_no_retry: got %0d requests required 1", log_op.size() - base);
        end
        start = 1'b1;
        rx_drive(16'h0002, MAA, TGT, LIP);
        step(1);
        start = 1'b0;
        arp_rx_valid = 1'b0;
        tests++;
        if ({peer_mac, peer_mac_valid, busy} !== {M5, 2'b01}) begin
            fails++;
            $display("FAIL restart: got peer=%h valid=%b busy=%b required %h 0 1",
                     peer_mac, peer_mac_valid, busy, M5);
        end
        step(2);
        tests++;
        if (log_op.size() - base !== 2) begin
            fails++;
            $display("FAIL restart_req: got %0d requests required 2", log_op.size() - base);
        end else begin
            tests++;
            if ({log_op[base+1], log_ip[base+1]} !== {16'h0001, TGT}) begin
                fails++;
                $display("FAIL restart_fields: got op=%h ip=%h required 0001 %h",
                         log_op[base+1], log_ip[base+1], TGT);
            end
        end
    endtask

    // Reset during REQ_TX with ack low drops the request at once, no completion.
    task automatic test_reset_mid_handshake();
        int base;
        base = log_op.size();
        arp_tx_ack = 1'b0;
        start = 1'b1;
        step(1);
        start = 1'b0;
        tests++;
        if ({arp_tx_req, arp_tx_op, arp_tx_dst_ip} !== {1'b1, 16'h0001, TGT}) begin
            fails++;
            $display("FAIL mid_req: got req=%b op=%h ip=%h required 1 0001 %h",
                     arp_tx_req, arp_tx_op, arp_tx_dst_ip, TGT);
        end
        #2;
        rstn = 1'b0;
        #1;
        tests++;
        if ({arp_tx_req, busy, peer_mac_valid, resolve_fail} !== 4'b0000) begin
            fails++;
            $display("FAIL async_reset: got req/busy/valid/fail=%b required 0000",
                     {arp_tx_req, busy, peer_mac_valid, resolve_fail});
        end
        tests++;
        if ({arp_tx_op, arp_tx_dst_mac, arp_tx_dst_ip, peer_mac} !== 144'd0) begin
            fails++;
            $display("FAIL async_reset_fields: got op=%h mac=%h ip=%h peer=%h required all 0",
                     arp_tx_op, arp_tx_dst_mac, arp_tx_dst_ip, peer_mac);
        end
        arp_tx_ack = 1'b1;
        step(3);
        rstn = 1'b1;
        step(3);
        tests++;
        if ({arp_tx_req, busy} !== 2'b00 || log_op.size() !== base) begin
            fails++;
            $display("FAIL no_completion: got req=%b busy=%b handshakes=%0d required 0 0 0",
                     arp_tx_req, busy, log_op.size() - base);
        end
    endtask

    initial begin
        test_reset();
        test_retry_fail();
        do_reset();
        test_resolve();
        do_reset();
        test_reply_idle();
        do_reset();
        test_reply_during_wait();
        do_reset();
        test_hit_on_expiry();
        do_reset();
        test_reset_mid_handshake();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/arp_ctrl.md
ARP_CTRL -- requirements
Module: arp_ctrl

Interface
REQ-001 Parameter RETRY_CYCLES, default 32'd1_000_000, SHALL set the wait in clk cycles for a reply after each ARP request.
REQ-002 Parameter MAX_RETRY, default 3, SHALL set the number of requests sent before resolution fails.
REQ-003 Ports SHALL be:
 clk  in  1  clock
 rstn  in  1  reset, asynchronous, active-low
 start  in  1  pulse, begin resolving target_ip
 local_mac  in  48  own MAC address
 local_ip  in  32  own IP address
 target_ip  in  32  peer IP to resolve, sampled on start
 arp_rx_valid  in  1  one-cycle strobe, parsed ARP frame
 arp_rx_op  in  16  ARP opcode of the received frame
 arp_rx_src_mac  in  48  sender MAC
 arp_rx_src_ip  in  32  sender IP
 arp_rx_dst_ip  in  32  target IP
 arp_tx_req  out  1  transmit request to the ARP frame builder
 arp_tx_ack  in  1  builder accepts the request
 arp_tx_op  out  16  opcode to send
 arp_tx_dst_mac  out  48  destination MAC
 arp_tx_dst_ip  out  32  destination IP
 peer_mac  out  48  resolved peer MAC
 peer_mac_valid  out  1  peer_mac is current
 resolve_fail  out  1  MAX_RETRY requests sent with no reply
 busy  out  1  resolution in progress

Function
REQ-004 The FSM SHALL have the states IDLE, REQ_TX, REQ_WAIT and RPL_TX.
REQ-005 start in IDLE SHALL latch target_ip, clear peer_mac_valid, resolve_fail and the retry count, set busy, and enter REQ_TX on the next cycle; start outside IDLE SHALL be ignored.
REQ-006 In REQ_TX, arp_tx_req=1, arp_tx_op=16'h0001, arp_tx_dst_mac=48'hFFFF_FFFF_FFFF, and arp_tx_dst_ip=latched target.
REQ-007 arp_tx_req and all arp_tx_* fields SHALL hold stable until the cycle arp_tx_req&&arp_tx_ack; arp_tx_req SHALL be 0 on the following cycle.
REQ-008 Acceptance in REQ_TX SHALL increment the retry count, clear the timer and enter REQ_WAIT.
REQ-009 In REQ_WAIT the timer SHALL count every cycle; when it reaches RETRY_CYCLES-1: if retry count==MAX_RETRY, resolve_fail=1, busy=0 and the FSM goes to IDLE; otherwise the FSM goes to REQ_TX.
REQ-010 A cache hit is any arp_rx_valid with arp_rx_src_ip==latched target and opcode 1 or 2. On a hit: peer_mac<=arp_rx_src_mac and peer_mac_valid=1 on the next cycle; in REQ_WAIT the FSM goes to IDLE with busy=0 and resolve_fail=0.
REQ-011 A reply pending is set when arp_rx_valid&&arp_rx_op==16'h0001&&arp_rx_dst_ip==local_ip; it captures src_mac/src_ip into a one-deep latch. A newer request SHALL overwrite an unissued one.
REQ-012 From IDLE or REQ_WAIT with reply pending, the FSM SHALL enter RPL_TX; the REQ_WAIT timer SHALL freeze while in RPL_TX.
REQ-013 In RPL_TX, arp_tx_op=16'h0002 and dst_mac/dst_ip come from the latch; acceptance SHALL clear pending and return to REQ_WAIT if busy, else IDLE.
REQ-014 Reply pending SHALL NOT preempt REQ_TX; it is served after that acceptance, before REQ_WAIT timing resumes.
REQ-015 Simultaneous events:
 - A hit and a timer expiry in the same cycle: the hit wins and no retry is sent.
 - start and a hit in the same cycle in IDLE: start wins and the cache is not updated.
 - Pending capture and acceptance of a reply in the same cycle: the new request stays pending.
REQ-016 The retry count SHALL be $clog2(MAX_RETRY+1) bits wide and SHALL saturate; the timer SHALL be 32 bits.

Reset
REQ-017 While rstn=0, all of the following SHALL be 0 and the FSM SHALL be in IDLE: every output, the latched target, the reply latch, pending, the timer and the retry count.
REQ-018 Reset asserted mid-handshake SHALL drop arp_tx_req immediately (asynchronously), with no completion afterwards.

Structure
REQ-019 Package arp_pkg SHALL hold ARP_OP_REQ=16'h0001, ARP_OP_RPL=16'h0002, MAC_BCAST=48'hFFFF_FFFF_FFFF and the FSM state enum.
REQ-020 The retry timer (clear, enable and freeze inputs; expiry output) SHALL be sub-module arp_retry_timer.

Verification
REQ-021 RETRY_CYCLES=100 and MAX_RETRY=3 SHALL be used for the following scenarios:
 - start with target 10.0.0.2 and no rx -> three requests about 100 cycles apart; after the third expiry resolve_fail=1, busy=0, peer_mac_valid=0.
 - start, then after the first request a reply op=2 src_ip=10.0.0.2 src_mac=02:00:00:00:00:05 -> peer_mac=0x020000000005, valid=1, busy=0, no further requests.
 - Rx request dst_ip=local_ip in IDLE -> one arp_tx_req op=2 to the sender MAC/IP; with ack held low for 10 cycles, the fields stay stable.
 - Rx request to local_ip during REQ_WAIT at timer=50 -> reply sent, then the timer resumes from 50 and expires 50 cycles after RPL_TX exit.
 - A hit in the same cycle as timer expiry -> no request sent, resolved; start again -> valid cleared, new request sent.
 - Reset asserted during REQ_TX with ack=0 -> arp_tx_req=0 immediately, FSM IDLE, all outputs 0.
